piso_shift_register_8bit: RTL and testbench
===========================================

PISO_SHIFT_REGISTER_8BIT -- requirements
Module: piso_shift_register_8bit

Interface
REQ-001 The block SHALL have one parameter: MSB_FIRST, default 0, where 0 = transmit bit 0 first and 1 = transmit bit 7 first.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, named CLK and RST.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 RST  input  1  asynchronous active-high reset.
REQ-005 data_in  input  8  parallel word to serialize; sampled only on the load handshake.
REQ-006 load_valid  input  1  producer has a word on data_in.
REQ-007 load_ready  output  1  block can accept a word.
REQ-008 hold  input  1  pauses shifting while high.
REQ-009 serial_out  output  1  current serial bit.
REQ-010 serial_valid  output  1  serial_out carries a valid frame bit this cycle.
REQ-011 busy  output  1  a word is being serialized (SHIFT or DONE state).
REQ-012 done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-013 All outputs SHALL be registered; there SHALL be no combinational path from input to output.
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE the outputs SHALL be: load_ready=1, busy=0, serial_valid=0, serial_out=0, done=0.
REQ-016 A handshake SHALL occur at a rising edge where load_valid=1 and load_ready=1.
REQ-017 On a handshake, the block SHALL capture data_in into an 8-bit shift register, clear a 3-bit bit counter, and go to SHIFT.
REQ-018 load_ready SHALL be 1 only in IDLE; load_valid and data_in SHALL be ignored in SHIFT and DONE.
REQ-019 In SHIFT with hold=0: serial_valid=1; serial_out = the next bit (bit 0 first when MSB_FIRST=0, bit 7 first when MSB_FIRST=1); each edge advances the shift register by one and increments the counter.
REQ-020 For a handshake at edge k with hold=0 throughout: bit n SHALL be on serial_out during the cycle after edge k+n (n=0..7); done=1 in the cycle after edge k+8; load_ready=1 again after edge k+9.
REQ-021 In SHIFT with hold=1: shift register and counter SHALL freeze; serial_out SHALL hold its value; serial_valid SHALL be 0; shifting resumes on the first edge with hold=0.
REQ-022 The SHIFT->DONE transition SHALL occur on the edge that consumes the bit at counter=7 with hold=0; the counter SHALL not wrap within a word.
REQ-023 In DONE: done=1, busy=1, serial_valid=0, serial_out=0, load_ready=0; the next edge SHALL go to IDLE unconditionally, regardless of hold.
REQ-024 hold SHALL have no effect in IDLE or DONE.
REQ-025 Minimum spacing between handshakes SHALL be 10 cycles; back-to-back throughput is 8 bits per 10 cycles.

Reset
REQ-026 RST=1 SHALL asynchronously force: state=IDLE, shift register=8'h00, counter=0, load_ready=1, busy=0, serial_valid=0, serial_out=0, done=0.
REQ-027 Reset asserted during SHIFT or DONE SHALL discard the word in flight, with no done pulse.
REQ-028 After RST is released, the first handshake SHALL be accepted on the first rising edge.

Verification
REQ-029 Scenario: MSB_FIRST=0, load 8'hA5, hold=0 -> serial_out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with serial_valid=1; done pulses exactly once; load_ready returns after edge k+9.
REQ-030 Scenario: MSB_FIRST=1, load 8'hA5 -> serial_out = 1,0,1,0,0,1,0,1 (bit 7 first); load 8'h01 -> seven 0s then a 1.
REQ-031 Scenario: load 8'hF0 (LSB first), hold=1 for 3 cycles after bit 2 -> serial_valid=0 and serial_out frozen at 0 for 3 cycles; sequence then resumes with 0,1,1,1,1; done is delayed by 3 cycles.
REQ-032 Scenario: load_valid held high with data_in changing every cycle -> exactly one word is captured per 10 cycles, and the transmitted bits match the word captured at each handshake.
REQ-033 Scenario: RST pulsed asynchronously (between edges) after bit 4 of 8'hFF -> outputs immediately take reset values, no done pulse; a new load of 8'h3C then transmits correctly.
REQ-034 Scenario: load_valid=0 for 20 cycles after reset -> serial_valid=0, busy=0, done=0 and load_ready=1 throughout.

Source files
------------

// File: rtl/piso_shift_register_8bit.sv
// 8-bit parallel-in / serial-out shifter with a valid/ready load handshake,
// a hold input that stalls the frame, and a one-cycle done pulse per word.
module piso_shift_register_8bit #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] data_in,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic       hold,
    output logic       serial_out,
    output logic       serial_valid,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   shift_reg;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift_adv;

    // Bit of a word that goes out first for the configured bit order.
    function automatic logic lead_bit(input logic [DATA_W-1:0] word);
        return MSB_FIRST ? word[DATA_W-1] : word[0];
    endfunction

    // Shift register contents once the bit currently on serial_out is consumed.
    always_comb begin
        shift_adv = shift_reg;
        if (MSB_FIRST) begin
            shift_adv = {shift_reg[DATA_W-2:0], 1'b0};
        end else begin
            shift_adv = {1'b0, shift_reg[DATA_W-1:1]};
        end
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            load_ready   <= 1'b1;
            busy         <= 1'b0;
            serial_valid <= 1'b0;
            serial_out   <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        // Word is presented immediately: its first bit is valid
                        // in the cycle right after the handshake edge.
                        state        <= SHIFT;
                        shift_reg    <= data_in;
                        bit_cnt      <= '0;
                        load_ready   <= 1'b0;
                        busy         <= 1'b1;
                        serial_valid <= 1'b1;
                        serial_out   <= lead_bit(data_in);
                        done         <= 1'b0;
                    end else begin
                        load_ready   <= 1'b1;
                        busy         <= 1'b0;
                        serial_valid <= 1'b0;
                        serial_out   <= 1'b0;
                        done         <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (hold) begin
                        // Stall: keep the pending bit on the line but mark it invalid.
                        serial_valid <= 1'b0;
                    end else if (bit_cnt == LAST_CNT) begin
                        // Last bit consumed; counter stays put so it never wraps.
                        state        <= DONE;
                        shift_reg    <= shift_adv;
                        serial_valid <= 1'b0;
                        serial_out   <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        shift_reg    <= shift_adv;
                        bit_cnt      <= bit_cnt + CNT_W'(1);
                        serial_valid <= 1'b1;
                        serial_out   <= lead_bit(shift_adv);
                    end
                end

                DONE: begin
                    state        <= IDLE;
                    load_ready   <= 1'b1;
                    busy         <= 1'b0;
                    serial_valid <= 1'b0;
                    serial_out   <= 1'b0;
                    done         <= 1'b0;
                end

                default: begin
                    state        <= IDLE;
                    load_ready   <= 1'b1;
                    busy         <= 1'b0;
                    serial_valid <= 1'b0;
                    serial_out   <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_register_8bit.sv
// Directed bench for piso_shift_register_8bit: one LSB-first and one MSB-first
// instance share the same stimulus and are checked every cycle.
module tb_piso_shift_register_8bit;

    logic       CLK;
    logic       RST;
    logic [7:0] data_in;
    logic       load_valid;
    logic       hold;

    logic load_ready_l, serial_out_l, serial_valid_l, busy_l, done_l;
    logic load_ready_m, serial_out_m, serial_valid_m, busy_m, done_m;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       lv;
        logic [7:0] din;
        logic       hold;
        logic       r;
        logic       v;
        logic       b;
        logic       d;
        logic       sl;
        logic       sm;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] words[30];

    piso_shift_register_8bit #(.MSB_FIRST(1'b0)) dut_lsb (
        .CLK(CLK), .RST(RST), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready_l), .hold(hold), .serial_out(serial_out_l),
        .serial_valid(serial_valid_l), .busy(busy_l), .done(done_l)
    );

    piso_shift_register_8bit #(.MSB_FIRST(1'b1)) dut_msb (
        .CLK(CLK), .RST(RST), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready_m), .hold(hold), .serial_out(serial_out_m),
        .serial_valid(serial_valid_m), .busy(busy_m), .done(done_m)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check5(input string name, input int idx,
                          input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got ready/valid/busy/done/sout=%b expected %b",
                     name, idx, act, exp);
        end
    endtask

    task automatic check_both(input string name, input int idx,
                              input logic r, input logic v, input logic b,
                              input logic d, input logic sl, input logic sm);
        check5({name, "_lsb"}, idx,
               {load_ready_l, serial_valid_l, busy_l, done_l, serial_out_l},
               {r, v, b, d, sl});
        check5({name, "_msb"}, idx,
               {load_ready_m, serial_valid_m, busy_m, done_m, serial_out_m},
               {r, v, b, d, sm});
    endtask

    // Drive inputs after a falling edge, clock once, sample on the next falling edge.
    task automatic step(input logic lv, input logic [7:0] d, input logic h);
        load_valid = lv;
        data_in    = d;
        hold       = h;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic add(input logic lv, input logic [7:0] din, input logic h,
                       input logic r, input logic v, input logic b, input logic d,
                       input logic sl, input logic sm);
        vec_t e;
        e.lv = lv; e.din = din; e.hold = h;
        e.r = r; e.v = v; e.b = b; e.d = d; e.sl = sl; e.sm = sm;
        tbl.push_back(e);
    endtask

    // Load a word with no stalls and check all ten cycles of its frame.
    task automatic send_word(input string name, input logic [7:0] w);
        step(1'b1, w, 1'b0);
        check_both(name, 0, 1'b0, 1'b1, 1'b1, 1'b0, w[0], w[7]);
        for (int n = 1; n < 8; n++) begin
            step(1'b0, 8'h00, 1'b0);
            check_both(name, n, 1'b0, 1'b1, 1'b1, 1'b0, w[n], w[7-n]);
        end
        step(1'b0, 8'h00, 1'b0);
        check_both(name, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        check_both(name, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RST        = 1'b0;
        load_valid = 1'b0;
        data_in    = 8'h00;
        hold       = 1'b0;

        // Asynchronous reset takes effect without a clock edge.
        #2 RST = 1'b1;
        #1 check_both("reset_async", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        // Idle with no load requests.
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 8'(c * 13 + 7), 1'b0);
            check_both("idle20", c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // A5: both orders give 1,0,1,0,0,1,0,1; load_valid held high while busy.
        add(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        add(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // F0 with a 3-cycle stall after bit 2 and one more stall on bit 7.
        add(1'b1, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // 01: LSB-first gives a 1 then zeros, MSB-first gives seven 0s then a 1.
        add(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int n = 1; n < 7; n++)
            add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            step(tbl[i].lv, tbl[i].din, tbl[i].hold);
            check_both("table", i, tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].d,
                       tbl[i].sl, tbl[i].sm);
        end

        // Back-to-back: load_valid stuck high, data changes every cycle;
        // a word is taken every 10 cycles, namely the one present at that edge.
        for (int c = 0; c < 30; c++) begin
            int         ph;
            logic [7:0] w;
            words[c] = 8'(c * 37 + 11);
            step(1'b1, words[c], 1'b0);
            ph = c % 10;
            w  = words[c - ph];
            if (ph < 8)
                check_both("b2b", c, 1'b0, 1'b1, 1'b1, 1'b0, w[ph], w[7-ph]);
            else if (ph == 8)
                check_both("b2b", c, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            else
                check_both("b2b", c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Reset mid-word after bit 4 of FF, applied between clock edges.
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        for (int n = 1; n <= 4; n++) begin
            step(1'b0, 8'h00, 1'b0);
            check_both("ff_pre_rst", n, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        #2 RST = 1'b1;
        #1 check_both("rst_mid", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        check_both("rst_mid", 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;

        // First edge after reset release accepts a word.
        send_word("w3c", 8'h3C);
        send_word("w96", 8'h96);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
